// File: rtl/sc_stream_normalizer.sv
// Stochastic bitstream to normalized binary converter: counts the ones in LEN
// accepted stream bits, then emits mant = count << lz, exp = lz, zero flag.

module leading_zero_8 (
    input  logic [7:0] val_i,
    output logic [3:0] lz_o
);
    // Scanning upward lets the highest set bit overwrite the result last.
    always_comb begin
        lz_o = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (val_i[i]) lz_o = 4'(7 - i);
        end
    end
endmodule

module sc_stream_normalizer #(
    parameter int LEN = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] mant,
    output logic [3:0] exp,
    output logic       zero
);
    typedef enum logic [1:0] {ACC, NORM, OUT} state_t;

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_t     state_q;
    logic [7:0] bitcnt_q;
    logic [7:0] ones_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic [7:0] mant_q;
    logic [3:0] exp_q;
    logic       zero_q;
    logic [3:0] lz;

    leading_zero_8 u_lz (
        .val_i (ones_q),
        .lz_o  (lz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            bitcnt_q    <= 8'd0;
            ones_q      <= 8'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mant_q      <= 8'd0;
            exp_q       <= 4'd0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid && in_ready_q) begin
                        bitcnt_q <= bitcnt_q + 8'd1;
                        ones_q   <= ones_q + {7'd0, in_bit};
                        // The LEN-th bit is still counted before leaving ACC.
                        if (bitcnt_q == LAST_IDX) begin
                            state_q    <= NORM;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    // A zero count gives lz=8, which shifts everything out.
                    mant_q      <= ones_q << lz;
                    exp_q       <= lz;
                    zero_q      <= (ones_q == 8'd0);
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        bitcnt_q    <= 8'd0;
                        ones_q      <= 8'd0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ACC;
                    end
                end
                default: begin
                    state_q    <= ACC;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mant      = mant_q;
    assign exp       = exp_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_sc_stream_normalizer.sv
// Randomized bench for sc_stream_normalizer: instances with LEN=255, 16 and 1
// are checked against a count-and-normalize reference model.

module tb_sc_stream_normalizer;
    logic       clk = 1'b0;
    logic       rstv [3];
    logic       iv   [3];
    logic       ib   [3];
    logic       irdy [3];
    logic       ov   [3];
    logic       ordy [3];
    logic [7:0] mnt  [3];
    logic [3:0] ex   [3];
    logic       zr   [3];

    int n_checks = 0;
    int n_pass   = 0;
    int stalls;
    bit stim_q[$];

    always #5 clk = ~clk;

    sc_stream_normalizer #(.LEN(255)) dut0 (
        .clk(clk), .rst(rstv[0]), .in_valid(iv[0]), .in_bit(ib[0]), .in_ready(irdy[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .mant(mnt[0]), .exp(ex[0]), .zero(zr[0]));
    sc_stream_normalizer #(.LEN(16)) dut1 (
        .clk(clk), .rst(rstv[1]), .in_valid(iv[1]), .in_bit(ib[1]), .in_ready(irdy[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .mant(mnt[1]), .exp(ex[1]), .zero(zr[1]));
    sc_stream_normalizer #(.LEN(1)) dut2 (
        .clk(clk), .rst(rstv[2]), .in_valid(iv[2]), .in_bit(ib[2]), .in_ready(irdy[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .mant(mnt[2]), .exp(ex[2]), .zero(zr[2]));

    // Reference: shift the count left until its MSB is set; zero stays zero with exp 8.
    function automatic void model(input int cnt, output logic [7:0] m,
                                  output logic [3:0] e, output logic z);
        int v = cnt;
        int s = 0;
        if (cnt == 0) begin
            m = 8'h00; e = 4'd8; z = 1'b1;
            return;
        end
        while (v < 128) begin
            v = v * 2;
            s++;
        end
        m = v[7:0]; e = s[3:0]; z = 1'b0;
    endfunction

    function automatic int count_ones();
        int c = 0;
        foreach (stim_q[i]) c += int'(stim_q[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input int len, input int nones);
        stim_q.delete();
        for (int i = 0; i < len; i++) stim_q.push_back(i < nones);
        for (int i = len - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            bit t = stim_q[i];
            stim_q[i] = stim_q[j];
            stim_q[j] = t;
        end
    endtask

    // Presents stim_q with optional idle gaps (junk in_bit while in_valid=0);
    // returns one sample point after the edge that accepted the last bit.
    task automatic feed(input int k, input int gap_max);
        stalls = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    iv[k] = 1'b0; ib[k] = 1'($urandom); tick();
                end
            end
            if (!irdy[k]) stalls++;
            iv[k] = 1'b1; ib[k] = stim_q[i]; tick();
        end
        iv[k] = 1'b0; ib[k] = 1'b0;
    endtask

    task automatic wait_ov(input int k, output int cyc);
        cyc = 0;
        while (!ov[k] && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!ov[k]) cyc = -1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rstv[k] = 1'b1; iv[k] = 1'b0; ib[k] = 1'b0; ordy[k] = 1'b0;
        end
        tick(); tick();
        for (int k = 0; k < 3; k++) rstv[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (irdy[k] !== 1'b1 || ov[k] !== 1'b0) $display("FAIL reset_hs[%0d] got rdy=%b ov=%b want 1 0", k, irdy[k], ov[k]); else n_pass++;
            n_checks++;
            if ({mnt[k], ex[k], zr[k]} !== 13'd0) $display("FAIL reset_out[%0d] got %h/%0d/%b want 0/0/0", k, mnt[k], ex[k], zr[k]); else n_pass++;
        end
    endtask

    task automatic test_all_ones();
        int cyc;
        ordy[0] = 1'b1;
        build(255, 255);
        feed(0, 0);
        n_checks++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b0) $display("FAIL t1_norm got ov=%b rdy=%b want 0 0", ov[0], irdy[0]); else n_pass++;
        wait_ov(0, cyc);
        // Bit driven in the cycle before edge t; result visible in the cycle after edge t+1.
        n_checks++;
        if (cyc != 1) $display("FAIL t1_latency got %0d want 1", cyc); else n_pass++;
        n_checks++;
        if (mnt[0] !== 8'hFF || ex[0] !== 4'd0 || zr[0] !== 1'b0) $display("FAIL t1_result got %h/%0d/%b want ff/0/0", mnt[0], ex[0], zr[0]); else n_pass++;
        tick();
        n_checks++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) $display("FAIL t1_release got ov=%b rdy=%b want 0 1", ov[0], irdy[0]); else n_pass++;
    endtask

    task automatic test_all_zeros();
        int cyc;
        build(255, 0);
        feed(0, 2);
        wait_ov(0, cyc);
        n_checks++;
        if (cyc != 1) $display("FAIL t2_latency got %0d want 1", cyc); else n_pass++;
        n_checks++;
        if (mnt[0] !== 8'h00 || ex[0] !== 4'd8 || zr[0] !== 1'b1) $display("FAIL t2_result got %h/%0d/%b want 00/8/1", mnt[0], ex[0], zr[0]); else n_pass++;
        tick();
    endtask

    task automatic test_three_ones();
        int cyc;
        build(255, 3);
        feed(0, 1);
        wait_ov(0, cyc);
        n_checks++;
        if (cyc != 1 || mnt[0] !== 8'hC0 || ex[0] !== 4'd6 || zr[0] !== 1'b0) $display("FAIL t3_result got cyc=%0d %h/%0d/%b want 1 c0/6/0", cyc, mnt[0], ex[0], zr[0]); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int cyc;
        logic [7:0] em; logic [3:0] ee; logic ez;
        for (int it = 0; it < 5; it++) begin
            ordy[0] = 1'b0;
            build(255, $urandom_range(0, 255));
            model(count_ones(), em, ee, ez);
            feed(0, 2);
            wait_ov(0, cyc);
            repeat ($urandom_range(0, 3)) tick();
            n_checks++;
            if (cyc != 1 || stalls != 0) $display("FAIL rand%0d_timing got cyc=%0d stalls=%0d want 1 0", it, cyc, stalls); else n_pass++;
            n_checks++;
            if (ov[0] !== 1'b1 || mnt[0] !== em || ex[0] !== ee || zr[0] !== ez) $display("FAIL rand%0d_result got ov=%b %h/%0d/%b want 1 %h/%0d/%b", it, ov[0], mnt[0], ex[0], zr[0], em, ee, ez); else n_pass++;
            ordy[0] = 1'b1;
            tick();
        end
    endtask

    task automatic test_hold();
        int cyc;
        ordy[0] = 1'b0;
        build(255, 200);
        feed(0, 3);
        wait_ov(0, cyc);
        n_checks++;
        if (cyc != 1) $display("FAIL t4_latency got %0d want 1", cyc); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            iv[0] = i[0]; ib[0] = 1'b1;
            tick();
            n_checks++;
            if (ov[0] !== 1'b1 || irdy[0] !== 1'b0 || mnt[0] !== 8'hC8 || ex[0] !== 4'd0 || zr[0] !== 1'b0)
                $display("FAIL t4_hold%0d got ov=%b rdy=%b %h/%0d/%b want 1 0 c8/0/0", i, ov[0], irdy[0], mnt[0], ex[0], zr[0]);
            else n_pass++;
        end
        iv[0] = 1'b0; ib[0] = 1'b0; ordy[0] = 1'b1;
        tick();
        n_checks++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) $display("FAIL t4_release got ov=%b rdy=%b want 0 1", ov[0], irdy[0]); else n_pass++;
        build(255, 5);
        feed(0, 0);
        wait_ov(0, cyc);
        n_checks++;
        if (cyc != 1 || stalls != 0 || mnt[0] !== 8'hA0 || ex[0] !== 4'd5) $display("FAIL t4_next got cyc=%0d stalls=%0d %h/%0d want 1 0 a0/5", cyc, stalls, mnt[0], ex[0]); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        ordy[0] = 1'b0;
        build(100, 100);
        feed(0, 0);
        rstv[0] = 1'b1; tick(); rstv[0] = 1'b0;
        n_checks++;
        if (irdy[0] !== 1'b1 || ov[0] !== 1'b0) $display("FAIL t5_rst_acc got rdy=%b ov=%b want 1 0", irdy[0], ov[0]); else n_pass++;
        build(255, 255);
        feed(0, 0);
        wait_ov(0, cyc);
        n_checks++;
        if (cyc != 1 || stalls != 0) $display("FAIL t5_timing got cyc=%0d stalls=%0d want 1 0", cyc, stalls); else n_pass++;
        n_checks++;
        if (mnt[0] !== 8'hFF || ex[0] !== 4'd0 || zr[0] !== 1'b0) $display("FAIL t5_result got %h/%0d/%b want ff/0/0", mnt[0], ex[0], zr[0]); else n_pass++;
        tick();
        rstv[0] = 1'b1; tick(); rstv[0] = 1'b0;
        n_checks++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1 || {mnt[0], ex[0], zr[0]} !== 13'd0)
            $display("FAIL t5_rst_out got ov=%b rdy=%b %h/%0d/%b want 0 1 0/0/0", ov[0], irdy[0], mnt[0], ex[0], zr[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int hits[$];
        ordy[1] = 1'b1; iv[1] = 1'b1; ib[1] = 1'b1;
        for (int t = 0; t < 70; t++) begin
            tick();
            if (ov[1]) begin
                hits.push_back(t);
                n_checks++;
                if (mnt[1] !== 8'h80 || ex[1] !== 4'd3 || zr[1] !== 1'b0) $display("FAIL t6_result@%0d got %h/%0d/%b want 80/3/0", t, mnt[1], ex[1], zr[1]); else n_pass++;
            end
        end
        iv[1] = 1'b0;
        n_checks++;
        if (hits.size() < 3) $display("FAIL t6_count got %0d results want >=3", hits.size()); else n_pass++;
        for (int i = 1; i < hits.size(); i++) begin
            n_checks++;
            if (hits[i] - hits[i-1] != 18) $display("FAIL t6_period got %0d want 18", hits[i] - hits[i-1]); else n_pass++;
        end
    endtask

    task automatic test_len1();
        int cyc;
        logic [7:0] em; logic [3:0] ee; logic ez;
        ordy[2] = 1'b1;
        for (int it = 0; it < 6; it++) begin
            stim_q.delete();
            stim_q.push_back((it < 2) ? it[0] : 1'($urandom));
            model(count_ones(), em, ee, ez);
            feed(2, 1);
            wait_ov(2, cyc);
            n_checks++;
            if (cyc != 1 || mnt[2] !== em || ex[2] !== ee || zr[2] !== ez)
                $display("FAIL len1_%0d got cyc=%0d %h/%0d/%b want 1 %h/%0d/%b", it, cyc, mnt[2], ex[2], zr[2], em, ee, ez);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_three_ones();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_len1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
